// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate encoder datapath.
//   imm_src_e : ImmSrc format code, shared with the sign-extender and the
//               control unit.
//   imm_err_e : error code carried alongside each encoded instruction.
//   IMM_*_MIN/MAX : inclusive signed limits of each immediate format.
//   imm_src_known : returns 1 for the four encodable formats.
// -----------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011
  } imm_src_e;

  // Values double as the out_err encoding.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_FMT   = 2'b11
  } imm_err_e;

  // I and S carry a 12-bit signed field.
  localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_I_MAX =  32'sd2047;
  // B carries a 13-bit signed byte offset with bit 0 implied zero.
  localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX =  32'sd4094;
  // J carries a 21-bit signed byte offset with bit 0 implied zero.
  localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX =  32'sd1048574;

  function automatic logic imm_src_known(input logic [2:0] src);
    return (src == IMM_I) || (src == IMM_S) || (src == IMM_B) || (src == IMM_J);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Purely combinational field scatter: places the low immediate bits into the
// I/S/B/J immediate fields of a base instruction. All bits that are not part
// of the selected immediate field are copied from base. An unknown format
// returns base unchanged.
// Ports:
//   base  [31:0] in  : base instruction (opcode/rd/rs/funct preserved)
//   imm   [20:0] in  : low immediate bits (wider bits never reach a field)
//   src   [2:0]  in  : ImmSrc format code
//   instr [31:0] out : merged instruction
// -----------------------------------------------------------------------------
module imm_pack
  import imm_pkg::*;
(
  input  logic [31:0] base,
  input  logic [20:0] imm,
  input  logic [2:0]  src,
  output logic [31:0] instr
);

  always_comb begin
    instr = base;
    case (src)
      IMM_I: begin
        instr[31:20] = imm[11:0];
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
      end
      default: begin
        instr = base;
      end
    endcase
  end

endmodule

// File: rtl/imm_enc.sv
// -----------------------------------------------------------------------------
// imm_enc
// Streaming immediate encoder, the inverse of the immediate sign-extender.
// Stage 1 captures the transaction and classifies it (format, alignment,
// range). Stage 2 scatters the immediate into the instruction fields and
// holds the result until downstream accepts it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer keeps valid and its payload stable until the
// transfer; ready may change at any time and never depends on valid of the
// same interface. out_instr/out_err stay stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake
//   in_base  [31:0]       : base instruction
//   in_imm   [31:0]       : signed immediate (byte offset for B/J)
//   in_src   [2:0]        : format code (000 I, 001 S, 010 B, 011 J)
//   out_valid/out_ready   : output handshake
//   out_instr [31:0]      : encoded instruction
//   out_err   [1:0]       : 00 ok, 01 range, 10 misaligned, 11 bad format
//   enc_count [CNT_W-1:0] : output transfers completed (wraps)
//   err_count [ERR_W-1:0] : output transfers flagged with an error (saturates)
// -----------------------------------------------------------------------------
module imm_enc
  import imm_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_base,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_base_q,  s1_base_d;
  logic [20:0]      s1_imm_q,   s1_imm_d;
  logic [2:0]       s1_src_q,   s1_src_d;
  imm_err_e         s1_err_q,   s1_err_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [1:0]       out_err_q,   out_err_d;

  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  // ---------------------------------------------------------------------------
  // Pipeline enables: a stage may load when it is empty or when the stage in
  // front of it is moving on this edge.
  // ---------------------------------------------------------------------------
  logic s2_en;
  logic s1_en;
  logic out_xfer;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign out_xfer = s2_valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 checker. Priority: bad format, then misalignment, then range.
  // Comparing the full signed immediate against the field limits is the same
  // as requiring truncate-then-sign-extend to give the original value back.
  // ---------------------------------------------------------------------------
  logic signed [31:0] imm_s;
  logic signed [31:0] lim_lo;
  logic signed [31:0] lim_hi;
  logic               need_align;
  imm_err_e           chk_err;

  assign imm_s = $signed(in_imm);

  always_comb begin
    lim_lo     = IMM_I_MIN;
    lim_hi     = IMM_I_MAX;
    need_align = 1'b0;
    case (in_src)
      IMM_I, IMM_S: begin
        lim_lo = IMM_I_MIN;
        lim_hi = IMM_I_MAX;
      end
      IMM_B: begin
        lim_lo     = IMM_B_MIN;
        lim_hi     = IMM_B_MAX;
        need_align = 1'b1;
      end
      IMM_J: begin
        lim_lo     = IMM_J_MIN;
        lim_hi     = IMM_J_MAX;
        need_align = 1'b1;
      end
      default: begin
        lim_lo     = IMM_I_MIN;
        lim_hi     = IMM_I_MAX;
        need_align = 1'b0;
      end
    endcase
  end

  always_comb begin
    chk_err = ERR_NONE;
    if (!imm_src_known(in_src)) begin
      chk_err = ERR_FMT;
    end else if (need_align && in_imm[0]) begin
      chk_err = ERR_ALIGN;
    end else if ((imm_s < lim_lo) || (imm_s > lim_hi)) begin
      chk_err = ERR_RANGE;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 field merge
  // ---------------------------------------------------------------------------
  logic [31:0] pack_instr;

  imm_pack u_pack (
    .base  (s1_base_q),
    .imm   (s1_imm_q),
    .src   (s1_src_q),
    .instr (pack_instr)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_base_d   = s1_base_q;
    s1_imm_d    = s1_imm_q;
    s1_src_d    = s1_src_q;
    s1_err_d    = s1_err_q;
    s2_valid_d  = s2_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;

    if (s1_en) begin
      s1_valid_d = in_valid;
      // Payload only moves with a real transfer so idle cycles leave it alone.
      if (in_valid) begin
        s1_base_d = in_base;
        s1_imm_d  = in_imm[20:0];
        s1_src_d  = in_src;
        s1_err_d  = chk_err;
      end
    end

    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = pack_instr;
        out_err_d   = s1_err_q;
      end
    end

    if (out_xfer) begin
      enc_count_d = enc_count_q + CNT_W'(1);
      if ((out_err_q != ERR_NONE) && (err_count_q != {ERR_W{1'b1}})) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_base_q   <= '0;
      s1_imm_q    <= '0;
      s1_src_q    <= '0;
      s1_err_q    <= ERR_NONE;
      s2_valid_q  <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= '0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_base_q   <= s1_base_d;
      s1_imm_q    <= s1_imm_d;
      s1_src_q    <= s1_src_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = s1_en;
  assign out_valid = s2_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
